// File: rtl/sensor_sched.sv
// sensor_sched: measurement scheduler for the ultrasonic sensor core.
// Latency: fire_measure one cycle after a request; result registered one cycle after done/timeout.
// Backpressure: none; a result that overwrites an unacked result sets sticky overrun.
//
// Ports:
//   clk_sys       system clock (only clock)
//   rst_n         asynchronous active-low reset
//   enable        level, periodic measurements while high
//   start         one-cycle pulse, single measurement request when idle
//   fire_measure  one-cycle pulse to the sensor core
//   done_measure  one-cycle pulse from the sensor core (echo falling edge)
//   data_measure  echo high-time count, valid with done_measure
//   result_data   latched measurement, or all-ones after a timeout
//   result_vld    high while result_data is unread
//   result_ack    one-cycle pulse, host consumed the result
//   err_timeout   one-cycle pulse, registered alongside the timeout result
//   overrun       sticky, a published result overwrote an unacked one
//   busy          high in FIRE or WAIT
//
// Optional build macro SENSOR_SCHED_AVG_EN: publish the average of every 4
// successful samples instead of each sample.
module sensor_sched #(
  parameter logic [31:0] PERIOD  = 32'd5_000_000,
  parameter logic [31:0] TIMEOUT = 32'd3_000_000
) (
  input  logic        clk_sys,
  input  logic        rst_n,
  input  logic        enable,
  input  logic        start,
  output logic        fire_measure,
  input  logic        done_measure,
  input  logic [31:0] data_measure,
  output logic [31:0] result_data,
  output logic        result_vld,
  input  logic        result_ack,
  output logic        err_timeout,
  output logic        overrun,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE, FIRE, WAIT, HOLD} state_t;

  state_t      state;
  state_t      state_nxt;
  logic [31:0] period_cnt;
  logic [31:0] timeout_cnt;
  logic        done_hit;
  logic        timeout_hit;
  logic        finish;
  logic        publish;
  logic [31:0] publish_data;

  // done wins over a coincident timeout, so the timeout qualifier excludes done
  assign done_hit    = (state == WAIT) && done_measure;
  assign timeout_hit = (state == WAIT) && !done_measure &&
                       (timeout_cnt == TIMEOUT - 32'd1);
  assign finish      = done_hit || timeout_hit;

  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt    = state;
    fire_measure = 1'b0;
    busy         = 1'b0;
    case (state)
      IDLE: begin
        // enable and start together collapse into a single request
        if (enable || start) state_nxt = FIRE;
      end
      FIRE: begin
        fire_measure = 1'b1;
        busy         = 1'b1;
        state_nxt    = WAIT;
      end
      WAIT: begin
        busy = 1'b1;
        if (finish) state_nxt = HOLD;
      end
      HOLD: begin
        if (!enable)                             state_nxt = IDLE;
        else if (period_cnt == PERIOD - 32'd1)   state_nxt = FIRE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Period counter is 0 during the FIRE cycle, so HOLD leaving at PERIOD-1
  // puts the next FIRE exactly PERIOD cycles after the previous one.
  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n)
      period_cnt <= '0;
    else if (state == IDLE || state_nxt == FIRE)
      period_cnt <= '0;
    else if (period_cnt != PERIOD - 32'd1)
      period_cnt <= period_cnt + 32'd1;
  end

  // Timeout counter is 0 in the first WAIT cycle; the TIMEOUT-th WAIT cycle
  // is the last one allowed.
  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n)              timeout_cnt <= '0;
    else if (state == WAIT)  timeout_cnt <= timeout_cnt + 32'd1;
    else                     timeout_cnt <= '0;
  end

`ifdef SENSOR_SCHED_AVG_EN
  logic [33:0] acc;
  logic [33:0] acc_sum;
  logic [1:0]  smp_cnt;
  logic        last_smp;

  assign acc_sum      = acc + {2'b00, data_measure};
  assign last_smp     = done_hit && (smp_cnt == 2'd3);
  assign publish      = timeout_hit || last_smp;
  assign publish_data = timeout_hit ? 32'hFFFF_FFFF : acc_sum[33:2];

  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      acc     <= '0;
      smp_cnt <= '0;
    end else if (timeout_hit || last_smp) begin
      acc     <= '0;
      smp_cnt <= '0;
    end else if (done_hit) begin
      acc     <= acc_sum;
      smp_cnt <= smp_cnt + 2'd1;
    end
  end
`else
  assign publish      = finish;
  assign publish_data = done_hit ? data_measure : 32'hFFFF_FFFF;
`endif

  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      result_data <= '0;
      result_vld  <= 1'b0;
      err_timeout <= 1'b0;
      overrun     <= 1'b0;
    end else begin
      err_timeout <= timeout_hit;
      if (publish) begin
        result_data <= publish_data;
        result_vld  <= 1'b1;
        // a same-cycle ack consumes the old result, so it is not an overrun
        if (result_vld && !result_ack) overrun <= 1'b1;
      end else if (result_ack) begin
        result_vld <= 1'b0;
      end
    end
  end

endmodule
